// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one registered binary/Gray conversion stage
// among NREQ requesters; results leave through a one-deep valid/ready register.
module gray_conv_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   input  logic [NREQ-1:0]       req_mode,
   output logic [NREQ-1:0]       req_ready,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WIDTH-1:0]      rsp_data,
   output logic [IDW-1:0]        rsp_id
);

   logic [IDW-1:0]   ptr_reg;
   logic [IDW-1:0]   ptr_next;
   logic             rsp_valid_reg;
   logic [WIDTH-1:0] rsp_data_reg;
   logic [IDW-1:0]   rsp_id_reg;

   logic [WIDTH-1:0] conv [NREQ];
   logic             grant_found;
   logic [IDW-1:0]   grant_idx;
   logic [IDW:0]     scan_sum;
   logic             can_accept;
   logic             accept;

   // Every requester's word is converted in parallel; the grant only selects.
   genvar gi, gb;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_conv
         logic [WIDTH-1:0] word;
         logic [WIDTH-1:0] b2g;
         logic [WIDTH-1:0] g2b;
         assign word = req_data[gi*WIDTH +: WIDTH];
         assign b2g  = word ^ (word >> 1);
         for (gb = 0; gb < WIDTH; gb++) begin : g_bit
            assign g2b[gb] = ^(word >> gb);
         end
         assign conv[gi] = req_mode[gi] ? g2b : b2g;
      end
   endgenerate

   // Scan ptr, ptr+1, ... modulo NREQ and keep the first valid requester.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_sum    = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_sum = {1'b0, ptr_reg} + (IDW+1)'(k);
         if (scan_sum >= (IDW+1)'(NREQ))
            scan_sum = scan_sum - (IDW+1)'(NREQ);
         if (!grant_found && req_valid[scan_sum[IDW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = scan_sum[IDW-1:0];
         end
      end
   end

   assign can_accept = !rsp_valid_reg || rsp_ready;
   assign accept     = rst_n && can_accept && grant_found;
   assign req_ready  = accept ? (NREQ'(1) << grant_idx) : '0;
   assign ptr_next   = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg       <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_data_reg  <= '0;
         rsp_id_reg    <= '0;
      end else if (accept) begin
         ptr_reg       <= ptr_next;
         rsp_valid_reg <= 1'b1;
         rsp_data_reg  <= conv[grant_idx];
         rsp_id_reg    <= grant_idx;
      end else if (rsp_ready) begin
         rsp_valid_reg <= 1'b0;
      end
   end

   assign rsp_valid = rsp_valid_reg;
   assign rsp_data  = rsp_data_reg;
   assign rsp_id    = rsp_id_reg;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter with hand-computed expected values.
module tb_gray_conv_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 4;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_mode;
   logic [NREQ-1:0]       req_ready;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [WIDTH-1:0]      rsp_data;
   logic [IDW-1:0]        rsp_id;

   int checks = 0;
   int errors = 0;

   gray_conv_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_mode(req_mode),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_word(input int i, input logic [WIDTH-1:0] w, input logic m);
      req_data[i*WIDTH +: WIDTH] = w;
      req_mode[i] = m;
   endtask

   task automatic chk_rsp(input string tag, input logic [IDW-1:0] id, input logic [WIDTH-1:0] d);
      chk({tag, ".valid"}, rsp_valid, 1'b1);
      chk({tag, ".id"}, rsp_id, id);
      chk({tag, ".data"}, rsp_data, d);
      $display("txn %s: id=%0d data=%b", tag, rsp_id, rsp_data);
   endtask

   // Drive one word, check the grant before the edge and the result after it.
   task automatic single(input string tag, input int i, input logic [WIDTH-1:0] w,
                         input logic m, input logic [WIDTH-1:0] exp_d);
      set_word(i, w, m);
      #1;
      chk({tag, ".ready"}, req_ready, NREQ'(1) << i);
      tick();
      chk_rsp(tag, IDW'(i), exp_d);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      req_data  = '0;
      req_mode  = '0;
      rsp_ready = 1'b1;
      #3;
      chk("rst.valid", rsp_valid, 1'b0);
      chk("rst.data", rsp_data, 4'b0000);
      chk("rst.id", rsp_id, 2'd0);
      chk("rst.ready", req_ready, 4'b0000);
      req_valid = '0;
      #9 rst_n = 1'b1;
      tick();

      // Requester 0, binary to Gray
      req_valid = 4'b0001;
      single("b2g0", 0, 4'b1101, 1'b0, 4'b1011);
      single("b2g1", 0, 4'b1001, 1'b0, 4'b1101);
      single("b2g2", 0, 4'b0111, 1'b0, 4'b0100);
      single("b2g3", 0, 4'b1010, 1'b0, 4'b1111);

      // Requester 2, Gray to binary (ptr is 1 here)
      req_valid = 4'b0100;
      single("g2b0", 2, 4'b1011, 1'b1, 4'b1101);
      single("g2b1", 2, 4'b0100, 1'b1, 4'b0111);
      single("g2b2", 2, 4'b1111, 1'b1, 4'b1010);

      req_valid = '0;
      tick();
      chk("idle.valid", rsp_valid, 1'b0);
      chk("idle.data", rsp_data, 4'b1010);

      // Bring ptr from 3 back to 0
      req_valid = 4'b1000;
      single("ptr3", 3, 4'b0000, 1'b0, 4'b0000);

      // All valid: rotation 0,1,2,3,0,1 with data i -> gray(i)
      set_word(0, 4'd0, 1'b0);
      set_word(1, 4'd1, 1'b0);
      set_word(2, 4'd2, 1'b0);
      set_word(3, 4'd3, 1'b0);
      req_valid = 4'b1111;
      tick(); chk_rsp("rr0", 2'd0, 4'b0000);
      tick(); chk_rsp("rr1", 2'd1, 4'b0001);
      tick(); chk_rsp("rr2", 2'd2, 4'b0011);
      tick(); chk_rsp("rr3", 2'd3, 4'b0010);
      tick(); chk_rsp("rr4", 2'd0, 4'b0000);
      tick(); chk_rsp("rr5", 2'd1, 4'b0001);

      // Backpressure: pending 1011 from requester 0 (ptr 2 -> grants 0)
      req_valid = 4'b0001;
      single("bp.setup", 0, 4'b1101, 1'b0, 4'b1011);
      rsp_ready = 1'b0;
      set_word(1, 4'b0001, 1'b0);
      set_word(3, 4'b0011, 1'b0);
      req_valid = 4'b1010;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("bp.ready", req_ready, 4'b0000);
         tick();
         chk_rsp("bp.stall", 2'd0, 4'b1011);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp.rel.ready1", req_ready, 4'b0010);
      tick();
      chk_rsp("bp.rel1", 2'd1, 4'b0001);
      chk("bp.rel.ready3", req_ready, 4'b1000);
      tick();
      chk_rsp("bp.rel3", 2'd3, 4'b0010);

      // ptr is 0; one grant to requester 1 makes it 2
      req_valid = 4'b0010;
      single("skip.setup", 1, 4'b0001, 1'b0, 4'b0001);
      set_word(0, 4'b0100, 1'b0);
      req_valid = 4'b0011;
      #1 chk("skip.ready0", req_ready, 4'b0001);
      tick(); chk_rsp("skip0", 2'd0, 4'b0110);
      chk("skip.ready1", req_ready, 4'b0010);
      tick(); chk_rsp("skip1", 2'd1, 4'b0001);
      chk("skip.ready2", req_ready, 4'b0001);
      tick(); chk_rsp("skip2", 2'd0, 4'b0110);
      req_valid = '0;
      tick();
      tick();
      chk("skip.idle.valid", rsp_valid, 1'b0);
      req_valid = 4'b0011;
      #1 chk("skip.hold", req_ready, 4'b0010);
      tick(); chk_rsp("skip3", 2'd1, 4'b0001);

      // Asynchronous reset mid-cycle with a result pending
      rst_n = 1'b0;
      #1;
      chk("mrst.valid", rsp_valid, 1'b0);
      chk("mrst.data", rsp_data, 4'b0000);
      chk("mrst.id", rsp_id, 2'd0);
      chk("mrst.ready", req_ready, 4'b0000);
      req_valid = 4'b1111;
      #5 rst_n = 1'b1;
      #1 chk("mrst.first.ready", req_ready, 4'b0001);
      tick();
      chk_rsp("mrst.first", 2'd0, 4'b0110);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
